// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display.
// Segment bit order (a..g, dp) and the hex font used by hex_to_seg.
package seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef logic [6:0] seg7_t;

   // Active-high glyphs, bit SEG_x lights segment x (g..a from MSB to LSB).
   localparam seg7_t HEX_FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to seven-segment glyph decoder (purely combinational).
// Ports: nib in [3:0] hex value; seg out [6:0] active-high a..g pattern.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output seg7_t      seg
);

   always_comb begin
      seg = HEX_FONT[nib];
   end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with tear-free frame updates,
// PWM brightness and leading-zero blanking.
// Ports: clk, rst (sync, high); data/dp/load capture new content;
// blank_lz, bright shape output; enpos/seg drive the display;
// pending flags a buffered load; frame_tick pulses after each frame.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int DIV      = 5000,
   parameter int BRIGHT_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   input  logic                  blank_lz,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [DIGITS-1:0]     enpos,
   output logic [7:0]            seg,
   output logic                  pending,
   output logic                  frame_tick
);

   localparam int CW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   // Wide enough for (2**BRIGHT_W) * DIV without overflow.
   localparam int TW = BRIGHT_W + CW + 1;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   sh_data_q, sh_data_d;
   logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
   logic [4*DIGITS-1:0]   bf_data_q, bf_data_d;
   logic [DIGITS-1:0]     bf_dp_q, bf_dp_d;
   logic                  pending_q, pending_d;
   logic [DIGITS-1:0]     enpos_q, enpos_d;
   logic [7:0]            seg_q, seg_d;
   logic                  ft_q, ft_d;

   logic                  slot_tick;
   logic                  boundary;
   logic [TW-1:0]         thr;
   logic                  lit;
   logic [3:0]            nib;
   seg7_t                 glyph;
   logic [DIGITS-1:0]     lz;
   logic                  lz_acc;
   logic                  blank;

   hex_to_seg u_dec (
      .nib (nib),
      .seg (glyph)
   );

   always_comb begin
      slot_tick = (cnt_q == CW'(DIV - 1));
      boundary  = slot_tick && (idx_q == IW'(DIGITS - 1));

      cnt_d = slot_tick ? '0 : cnt_q + CW'(1);
      idx_d = idx_q;
      if (slot_tick) begin
         idx_d = boundary ? '0 : idx_q + IW'(1);
      end

      // Buffered loads land only on a frame boundary so a frame never
      // mixes old and new digits.
      sh_data_d = sh_data_q;
      sh_dp_d   = sh_dp_q;
      bf_data_d = bf_data_q;
      bf_dp_d   = bf_dp_q;
      pending_d = pending_q;
      if (load && boundary) begin
         sh_data_d = data;
         sh_dp_d   = dp;
         pending_d = 1'b0;
      end else if (load) begin
         bf_data_d = data;
         bf_dp_d   = dp;
         pending_d = 1'b1;
      end else if (boundary && pending_q) begin
         sh_data_d = bf_data_q;
         sh_dp_d   = bf_dp_q;
         pending_d = 1'b0;
      end

      thr = ((TW'(bright) + TW'(1)) * TW'(DIV)) >> BRIGHT_W;
      lit = (TW'(cnt_q) < thr);

      nib = sh_data_q[{idx_q, 2'b00} +: 4];

      // lz[k]: digits k..top are all zero with no decimal point.
      lz_acc = 1'b1;
      lz     = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lz_acc = lz_acc && (sh_data_q[4*k +: 4] == 4'h0) && !sh_dp_q[k];
         lz[k]  = lz_acc;
      end
      blank = blank_lz && lz[idx_q] && (idx_q != '0);

      enpos_d = lit ? (DIGITS'(1) << idx_q) : '0;
      seg_d   = '0;
      if (lit && !blank) begin
         seg_d[6:0]    = glyph;
         seg_d[SEG_DP] = sh_dp_q[idx_q];
      end

      ft_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_data_q <= '0;
         sh_dp_q   <= '0;
         bf_data_q <= '0;
         bf_dp_q   <= '0;
         pending_q <= 1'b0;
         enpos_q   <= '0;
         seg_q     <= '0;
         ft_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_data_q <= sh_data_d;
         sh_dp_q   <= sh_dp_d;
         bf_data_q <= bf_data_d;
         bf_dp_q   <= bf_dp_d;
         pending_q <= pending_d;
         enpos_q   <= enpos_d;
         seg_q     <= seg_d;
         ft_q      <= ft_d;
      end
   end

   assign enpos      = enpos_q;
   assign seg        = seg_q;
   assign pending    = pending_q;
   assign frame_tick = ft_q;

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV, default 5000, clk cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter BRIGHT_W, default 3, width of brightness control.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port data  in  4*DIGITS  hex nibbles, digit k = data[4k+3:4k].
REQ-007 SHALL have port dp  in  DIGITS  decimal-point request per digit.
REQ-008 SHALL have port load  in  1  one-cycle strobe capturing data and dp.
REQ-009 SHALL have port blank_lz  in  1  leading-zero blanking enable.
REQ-010 SHALL have port bright  in  BRIGHT_W  brightness level, 0 dimmest, all-ones full.
REQ-011 SHALL have port enpos  out  DIGITS  one-hot digit enable, active-high, registered.
REQ-012 SHALL have port seg  out  8  seg[6:0] segment pattern from decoder, seg[7] decimal point, registered.
REQ-013 SHALL have port pending  out  1  loaded value waiting for frame boundary.
REQ-014 SHALL have port frame_tick  out  1  one-cycle pulse when scan wraps to digit 0.

Function
REQ-015 SHALL run prescaler cnt 0..DIV-1, wrapping to 0; slot tick = (cnt == DIV-1).
REQ-016 SHALL advance digit index idx on slot tick, DIGITS-1 wraps to 0; frame boundary = slot tick with idx == DIGITS-1.
REQ-017 SHALL keep shadow registers for data/dp; displayed content comes only from shadow.
REQ-018 SHALL, on load without boundary, copy data/dp into pending buffer and set pending=1; a further load overwrites buffer.
REQ-019 SHALL, on frame boundary with pending=1 and no load, move buffer to shadow and clear pending.
REQ-020 SHALL, on load coincident with frame boundary, write incoming data/dp directly to shadow and leave pending=0.
REQ-021 SHALL pulse frame_tick in the cycle after each frame boundary.
REQ-022 SHALL compute on-threshold thr = ((bright+1)*DIV) >> BRIGHT_W; digit lit when cnt < thr; bright all-ones gives full slot.
REQ-023 SHALL drive enpos = (1 << idx) when lit, else all zero, one cycle after cnt/idx values (1-cycle output latency).
REQ-024 SHALL drive seg[6:0] from hex_to_seg of shadow nibble idx, seg[7] = shadow dp[idx], when lit; seg = 0 when unlit.
REQ-025 SHALL, with blank_lz=1, force seg=0 (enpos unchanged) for digit k when all nibbles k..DIGITS-1 are zero and dp[k..DIGITS-1] all zero; digit 0 never blanked.
REQ-026 SHALL ignore bright and blank_lz changes for the current output only until next cycle (no latching; combinational sample each cycle).

Reset
REQ-027 SHALL, while rst=1, set cnt=0, idx=0, shadow=0, buffer=0, pending=0, enpos=0, seg=0, frame_tick=0.
REQ-028 SHALL give rst priority over load; load during rst is discarded.
REQ-029 SHALL restart scan at digit 0, cnt 0, on the first cycle after rst falls, mid-frame or not.

Structure
REQ-030 SHALL place segment bit-order constants and decimal-point index in shared package seg_pkg.
REQ-031 SHALL instantiate existing hex_to_seg as the single sub-module, one instance, decoding the selected nibble.
REQ-032 SHALL size cnt as clog2(DIV) bits and idx as clog2(DIGITS) bits (minimum 1).

Verification (DIGITS=4, DIV=4, BRIGHT_W=2)
REQ-033 SHALL check reset: rst=1 for 3 cycles then release -> enpos=0, seg=0 during rst; enpos=0001 on cycle 2 after release, 0010 four cycles later.
REQ-034 SHALL check tear-free load: load data=16'h1234 mid-frame at idx=1 -> pending=1, digits still show 0 until boundary, then digit 0 shows 4, digit 3 shows 1, pending=0, frame_tick pulses once.
REQ-035 SHALL check coincident load: load 16'hABCD exactly on boundary cycle -> pending stays 0, next frame shows D,C,B,A.
REQ-036 SHALL check brightness: bright=0 -> thr=1, enpos high 1 of 4 cycles per slot; bright=3 -> high all 4 cycles.
REQ-037 SHALL check blanking: shadow=16'h0050, dp=0, blank_lz=1 -> digits 3,2 seg=0, digit 1 shows 5, digit 0 shows 0; dp=4'b1000 -> no blanking.
REQ-038 SHALL check reset mid-operation: rst asserted with pending=1 -> pending=0 and shadow=0 after release.
